// File: rtl/hazard_pkg.sv
// Shared constants and width helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

    localparam int unsigned REG_X0 = 0;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return r;
    endfunction

    // Counter width able to hold the longest interlock length.
    function automatic int unsigned lat_width(input int unsigned load_lat,
                                              input int unsigned alu_lat);
        int unsigned m;
        int unsigned w;
        m = (load_lat > alu_lat) ? load_lat : alu_lat;
        w = clog2(m + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side request and interlock response signals of the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned AW  = 5,
    parameter int unsigned PCW = 32
);
    logic           id_valid;
    logic           jal_id;
    logic           lui_id;
    logic           alu_src_id;
    logic           s_type_id;
    logic           reg_write_id;
    logic           mem_to_reg_id;
    logic [AW-1:0]  r1_addr_id;
    logic [AW-1:0]  r2_addr_id;
    logic [AW-1:0]  rd_addr_id;
    logic           flush_id;
    logic           mem_stall;
    logic           stall_pc;
    logic           stall_ifid;
    logic           bubble_idex;
    logic           load_use;
    logic [PCW-1:0] stall_cycles;

    modport master (
        output id_valid, jal_id, lui_id, alu_src_id, s_type_id, reg_write_id,
               mem_to_reg_id, r1_addr_id, r2_addr_id, rd_addr_id, flush_id, mem_stall,
        input  stall_pc, stall_ifid, bubble_idex, load_use, stall_cycles
    );

    modport slave (
        input  id_valid, jal_id, lui_id, alu_src_id, s_type_id, reg_write_id,
               mem_to_reg_id, r1_addr_id, r2_addr_id, rd_addr_id, flush_id, mem_stall,
        output stall_pc, stall_ifid, bubble_idex, load_use, stall_cycles
    );
endinterface

// File: rtl/hazard_pend_cnt.sv
// Per-register pending-result down-counter with a "set by load" tag.
module hazard_pend_cnt #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set,
    input  logic [CW-1:0] i_set_val,
    input  logic          i_set_ld,
    input  logic          i_dec_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_is_ld
);

    logic [CW-1:0] r_cnt;
    logic          r_is_ld;

    // A new producer overrides the countdown of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_is_ld <= 1'b0;
        end else if (i_set) begin
            r_cnt   <= i_set_val;
            r_is_ld <= i_set_ld;
        end else if (i_dec_en && (r_cnt != '0)) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_is_ld = r_is_ld;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage interlock: per-register pending-result scoreboard driving PC/IF-ID hold,
// ID/EX bubble and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned ALU_LAT  = 3,
    parameter int unsigned PCW      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int unsigned CW = lat_width(LOAD_LAT, ALU_LAT);

    logic [CW-1:0]  w_cnt   [NREG];
    logic           w_is_ld [NREG];
    logic           w_r1_used;
    logic           w_r2_used;
    logic           w_r1_hit;
    logic           w_r2_hit;
    logic           w_hazard;
    logic           w_stall;
    logic           w_issue;
    logic           w_ld_src;
    logic [CW-1:0]  w_set_val;
    logic [PCW-1:0] r_stall_cycles;

    // Operand usage decoded from the instruction class.
    assign w_r1_used = !(bus.jal_id || bus.lui_id);
    assign w_r2_used = w_r1_used && !(bus.alu_src_id && !bus.s_type_id);

    assign w_r1_hit = w_r1_used && (bus.r1_addr_id != AW'(REG_X0)) && (w_cnt[bus.r1_addr_id] != '0);
    assign w_r2_hit = w_r2_used && (bus.r2_addr_id != AW'(REG_X0)) && (w_cnt[bus.r2_addr_id] != '0);
    assign w_ld_src = (w_r1_hit && w_is_ld[bus.r1_addr_id]) || (w_r2_hit && w_is_ld[bus.r2_addr_id]);

    assign w_hazard = bus.id_valid && (w_r1_hit || w_r2_hit);
    assign w_stall  = w_hazard && !bus.flush_id && !bus.mem_stall;
    assign w_issue  = bus.id_valid && !w_hazard && !bus.flush_id && !bus.mem_stall;

    assign w_set_val = bus.mem_to_reg_id ? CW'(LOAD_LAT) : (FWD_EN ? '0 : CW'(ALU_LAT));

    assign w_cnt[0]   = '0;
    assign w_is_ld[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_pend
        logic w_set;
        assign w_set = w_issue && bus.reg_write_id && (bus.rd_addr_id == AW'(g));

        hazard_pend_cnt #(.CW(CW)) u_pend (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_set     (w_set),
            .i_set_val (w_set_val),
            .i_set_ld  (bus.mem_to_reg_id),
            .i_dec_en  (!bus.mem_stall),
            .o_cnt     (w_cnt[g]),
            .o_is_ld   (w_is_ld[g])
        );
    end

    // Saturating count of bubble cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PCW'(1);
        end
    end

    assign bus.stall_pc     = w_stall;
    assign bus.stall_ifid   = w_stall;
    assign bus.bubble_idex  = w_stall;
    assign bus.load_use     = w_stall && w_ld_src;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: three parameterisations share one stimulus stream.
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       valid;
        logic       jal;
        logic       lui;
        logic       alu_src;
        logic       s_type;
        logic       rw;
        logic       m2r;
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rd;
        logic       flush;
        logic       ms;
    } in_t;

    typedef struct {
        in_t   in;
        int    dut;
        logic  bub;
        logic  lu;
        string name;
    } vec_t;

    typedef struct {
        int    dut;
        logic  bub;
        logic  lu;
        string name;
    } exp_t;

    logic clk;
    logic rst_n;
    in_t  cur;
    int   n_pass;
    int   n_total;
    vec_t tbl[$];
    exp_t exp_q[$];

    hazard_scoreboard_if #(.AW(5), .PCW(32)) if_a ();
    hazard_scoreboard_if #(.AW(5), .PCW(4))  if_b ();
    hazard_scoreboard_if #(.AW(5), .PCW(32)) if_c ();

    assign {if_a.id_valid, if_a.jal_id, if_a.lui_id, if_a.alu_src_id, if_a.s_type_id,
            if_a.reg_write_id, if_a.mem_to_reg_id, if_a.r1_addr_id, if_a.r2_addr_id,
            if_a.rd_addr_id, if_a.flush_id, if_a.mem_stall} = cur;
    assign {if_b.id_valid, if_b.jal_id, if_b.lui_id, if_b.alu_src_id, if_b.s_type_id,
            if_b.reg_write_id, if_b.mem_to_reg_id, if_b.r1_addr_id, if_b.r2_addr_id,
            if_b.rd_addr_id, if_b.flush_id, if_b.mem_stall} = cur;
    assign {if_c.id_valid, if_c.jal_id, if_c.lui_id, if_c.alu_src_id, if_c.s_type_id,
            if_c.reg_write_id, if_c.mem_to_reg_id, if_c.r1_addr_id, if_c.r2_addr_id,
            if_c.rd_addr_id, if_c.flush_id, if_c.mem_stall} = cur;

    hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .FWD_EN(1'b1), .ALU_LAT(3), .PCW(32))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(3), .FWD_EN(1'b1), .ALU_LAT(3), .PCW(4))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .FWD_EN(1'b0), .ALU_LAT(3), .PCW(32))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(logic jal, logic lui, logic alu_src, logic s_type, logic rw,
                               logic m2r, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd);
        in_t v;
        v = '0;
        v.valid = 1'b1; v.jal = jal; v.lui = lui; v.alu_src = alu_src; v.s_type = s_type;
        v.rw = rw; v.m2r = m2r; v.r1 = r1; v.r2 = r2; v.rd = rd;
        return v;
    endfunction

    function automatic in_t lw(logic [4:0] rd, logic [4:0] rs1);
        return mk(0, 0, 1, 0, 1, 1, rs1, 5'd0, rd);
    endfunction
    function automatic in_t alu_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return mk(0, 0, 0, 0, 1, 0, rs1, rs2, rd);
    endfunction
    function automatic in_t alu_i(logic [4:0] rd, logic [4:0] rs1, logic [4:0] r2f);
        return mk(0, 0, 1, 0, 1, 0, rs1, r2f, rd);
    endfunction
    function automatic in_t sw(logic [4:0] rs2, logic [4:0] rs1);
        return mk(0, 0, 1, 1, 0, 0, rs1, rs2, 5'd0);
    endfunction
    function automatic in_t fl(in_t v);
        in_t t; t = v; t.flush = 1'b1; return t;
    endfunction
    function automatic in_t ms(in_t v);
        in_t t; t = v; t.ms = 1'b1; return t;
    endfunction
    function automatic in_t inval(in_t v);
        in_t t; t = v; t.valid = 1'b0; return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else n_pass++;
    endtask

    task automatic get_out(input int dut, output logic bub, output logic pc,
                           output logic ifid, output logic lu);
        case (dut)
            0:       begin bub = if_a.bubble_idex; pc = if_a.stall_pc; ifid = if_a.stall_ifid; lu = if_a.load_use; end
            1:       begin bub = if_b.bubble_idex; pc = if_b.stall_pc; ifid = if_b.stall_ifid; lu = if_b.load_use; end
            default: begin bub = if_c.bubble_idex; pc = if_c.stall_pc; ifid = if_c.stall_ifid; lu = if_c.load_use; end
        endcase
    endtask

    // Drive one ID-stage cycle, queue its expectation and compare mid-cycle.
    task automatic apply(input in_t v, input int dut, input logic bub, input logic lu, input string name);
        exp_t e;
        logic g_bub, g_pc, g_ifid, g_lu;
        @(posedge clk);
        #1;
        cur = v;
        e.dut = dut; e.bub = bub; e.lu = lu; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        get_out(e.dut, g_bub, g_pc, g_ifid, g_lu);
        check({e.name, ".bubble_idex"}, 32'(g_bub), 32'(e.bub));
        check({e.name, ".stall_pc"},    32'(g_pc),  32'(e.bub));
        check({e.name, ".stall_ifid"},  32'(g_ifid), 32'(e.bub));
        check({e.name, ".load_use"},    32'(g_lu),  32'(e.lu));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cur   = '0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic tv(input in_t v, input logic bub, input logic lu, input string name);
        vec_t t;
        t.in = v; t.dut = 0; t.bub = bub; t.lu = lu; t.name = name;
        tbl.push_back(t);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        cur     = '0;

        repeat (2) @(negedge clk);
        check("rst_a.bubble", 32'(if_a.bubble_idex), 0);
        check("rst_a.load_use", 32'(if_a.load_use), 0);
        check("rst_a.stall_cycles", if_a.stall_cycles, 0);
        check("rst_b.bubble", 32'(if_b.bubble_idex), 0);
        check("rst_b.stall_cycles", 32'(if_b.stall_cycles), 0);
        check("rst_c.bubble", 32'(if_c.bubble_idex), 0);
        check("rst_c.stall_cycles", if_c.stall_cycles, 0);
        rst_n = 1'b1;

        // Single load-use bubble with the default latency.
        apply(lw(5, 1),        0, 0, 0, "t1_lw");
        apply(alu_r(6, 5, 1),  0, 1, 1, "t1_dep_stall");
        apply(alu_r(6, 5, 1),  0, 0, 0, "t1_dep_issue");
        check("t1_stall_cycles", if_a.stall_cycles, 1);

        tv(lw(5, 1), 0, 0, "gap_lw");               tv('0, 0, 0, "gap_nop");
        tv(alu_r(6, 5, 1), 0, 0, "gap_dep");
        tv(lw(5, 1), 0, 0, "addi_lw");              tv(alu_i(7, 5, 0), 1, 1, "addi_stall");
        tv(alu_i(7, 5, 0), 0, 0, "addi_issue");
        tv(lw(5, 1), 0, 0, "jal_lw");               tv(mk(1, 0, 0, 0, 1, 0, 5, 5, 1), 0, 0, "jal_nouse");
        tv(lw(5, 1), 0, 0, "lui_lw");               tv(mk(0, 1, 0, 0, 1, 0, 5, 5, 2), 0, 0, "lui_nouse");
        tv(lw(5, 1), 0, 0, "imm_lw");               tv(alu_i(7, 1, 5), 0, 0, "imm_r2_masked");
        tv(lw(5, 1), 0, 0, "sw_lw");                tv(sw(5, 1), 1, 1, "sw_rs2_stall");
        tv(sw(5, 1), 0, 0, "sw_issue");
        tv(lw(0, 1), 0, 0, "x0_lw");                tv(alu_r(6, 0, 0), 0, 0, "x0_dep");
        tv(alu_r(3, 1, 2), 0, 0, "fwd_add");        tv(alu_r(4, 3, 3), 0, 0, "fwd_sub");
        tv(lw(5, 1), 0, 0, "fl_lw");                tv(fl(alu_r(6, 5, 1)), 0, 0, "fl_hazard");
        tv(alu_r(6, 5, 1), 0, 0, "fl_after");
        tv(fl(lw(5, 1)), 0, 0, "fl_lw_squashed");   tv(alu_r(6, 5, 1), 0, 0, "fl_no_pend");
        tv(lw(5, 1), 0, 0, "ms_lw");                tv(ms(alu_r(6, 5, 1)), 0, 0, "ms_frz1");
        tv(ms(alu_r(6, 5, 1)), 0, 0, "ms_frz2");    tv(alu_r(6, 5, 1), 1, 1, "ms_stall");
        tv(alu_r(6, 5, 1), 0, 0, "ms_issue");
        tv(ms(lw(5, 1)), 0, 0, "ms_lw_held");       tv(lw(5, 1), 0, 0, "ms_lw_go");
        tv(alu_r(6, 5, 1), 1, 1, "ms_lw_dep");      tv(alu_r(6, 5, 1), 0, 0, "ms_lw_dep_go");
        tv(lw(5, 1), 0, 0, "iv_lw");                tv(inval(alu_r(6, 5, 1)), 0, 0, "iv_no_stall");

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].in, tbl[i].dut, tbl[i].bub, tbl[i].lu, tbl[i].name);

        // Asynchronous reset during a stall.
        apply(lw(5, 1),       0, 0, 0, "rs_lw");
        apply(alu_r(6, 5, 1), 0, 1, 1, "rs_stall");
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_async.bubble", 32'(if_a.bubble_idex), 0);
        check("rs_async.stall_pc", 32'(if_a.stall_pc), 0);
        check("rs_async.stall_cycles", if_a.stall_cycles, 0);
        #2;
        rst_n = 1'b1;
        apply(alu_r(6, 5, 1), 0, 0, 0, "rs_cleared");

        // LOAD_LAT=3: three bubbles, paused but not lost under mem_stall.
        do_reset();
        apply(lw(5, 1),           1, 0, 0, "l3_lw");
        apply(alu_r(6, 5, 1),     1, 1, 1, "l3_b1");
        apply(alu_r(6, 5, 1),     1, 1, 1, "l3_b2");
        apply(alu_r(6, 5, 1),     1, 1, 1, "l3_b3");
        apply(alu_r(6, 5, 1),     1, 0, 0, "l3_issue");
        apply(lw(5, 1),           1, 0, 0, "l3m_lw");
        apply(alu_r(6, 5, 1),     1, 1, 1, "l3m_b1");
        apply(ms(alu_r(6, 5, 1)), 1, 0, 0, "l3m_frz1");
        apply(ms(alu_r(6, 5, 1)), 1, 0, 0, "l3m_frz2");
        apply(alu_r(6, 5, 1),     1, 1, 1, "l3m_b2");
        apply(alu_r(6, 5, 1),     1, 1, 1, "l3m_b3");
        apply(alu_r(6, 5, 1),     1, 0, 0, "l3m_issue");
        check("l3_stall_cycles", 32'(if_b.stall_cycles), 6);

        // Self-dependent load chain drives the 4-bit counter into saturation.
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            cur = lw(5, 5);
        end
        @(negedge clk);
        check("sat_stall_cycles", 32'(if_b.stall_cycles), 15);

        // No forwarding: ALU results interlock for ALU_LAT cycles.
        do_reset();
        apply(alu_r(3, 1, 2),  2, 0, 0, "nf_add");
        apply(alu_r(4, 3, 3),  2, 1, 0, "nf_b1");
        apply(alu_r(4, 3, 3),  2, 1, 0, "nf_b2");
        apply(alu_r(4, 3, 3),  2, 1, 0, "nf_b3");
        apply(alu_r(4, 3, 3),  2, 0, 0, "nf_issue");
        check("nf_stall_cycles", if_c.stall_cycles, 3);
        apply(lw(5, 1),        2, 0, 0, "nf_lw");
        apply(alu_r(6, 5, 1),  2, 1, 1, "nf_ld_stall");
        apply(alu_r(6, 5, 1),  2, 0, 0, "nf_ld_issue");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
